// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
// No logic; imported by the arbiter top and its watchdog.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_e;

    localparam int          NUM_MASTERS   = 2;
    localparam logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF;

    // One-hot owner view of the FSM state; zero while idle.
    function automatic logic [NUM_MASTERS-1:0] grant_of(input state_e s);
        return {s == BUSY1, s == BUSY0};
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Single-beat memory request/response bundle (valid held until ready pulse).
// The master side drives the request fields; the slave side returns ready/rdata.
interface mem_bus_arbiter_if;

    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport master (output valid, instr, addr, wdata, wstrb, input  ready, rdata);
    modport slave  (input  valid, instr, addr, wdata, wstrb, output ready, rdata);

endinterface

// File: rtl/mem_bus_arbiter_wdog.sv
// Saturating wait counter for a granted transfer; expires when it reaches TIMEOUT.
// Registered count, combinational expire; TIMEOUT = 0 disables expiry entirely.
module mem_arb_wdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expire
);

    localparam int            CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_expire = (TIMEOUT > 0) && (r_cnt == LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter onto one memory slave, with a transfer watchdog.
// One cycle of arbitration latency; slave ready passes straight back to the owner.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   resetn,
    mem_bus_arbiter_if.slave       m0,
    mem_bus_arbiter_if.slave       m1,
    mem_bus_arbiter_if.master      mem,
    output logic [NUM_MASTERS-1:0] grant,
    output logic                   timeout_err
);

    state_e      r_state;
    state_e      w_next;
    logic        r_last_owner;

    logic        w_busy;
    logic        w_sel1;
    logic        w_req_vld;
    logic        w_expire;
    logic        w_done;
    logic        w_tmo;
    logic [31:0] w_rsp_dat;

    assign w_busy    = (r_state != IDLE);
    assign w_sel1    = (r_state == BUSY1);
    assign w_req_vld = w_busy && (w_sel1 ? m1.valid : m0.valid);
    assign w_done    = w_req_vld && mem.ready;
    // A slave answer on the expiry cycle still counts as a normal completion.
    assign w_tmo     = w_req_vld && w_expire && !mem.ready;
    assign w_rsp_dat = w_tmo ? TIMEOUT_RDATA : mem.rdata;
    assign grant     = grant_of(r_state);

    mem_arb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk      (clk),
        .resetn   (resetn),
        .i_clr    (!w_busy),
        .i_inc    (w_busy && !mem.ready),
        .o_expire (w_expire)
    );

    // last_owner resets to m1 so that m0 wins the first tie.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_last_owner <= 1'b1;
        end else begin
            r_state <= w_next;
            if (w_done || w_tmo) begin
                r_last_owner <= w_sel1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (m0.valid && m1.valid) begin
                    w_next = r_last_owner ? BUSY0 : BUSY1;
                end else if (m0.valid) begin
                    w_next = BUSY0;
                end else if (m1.valid) begin
                    w_next = BUSY1;
                end
            end
            BUSY0, BUSY1: begin
                // Owner withdrawing its request also frees the bus.
                if (!w_req_vld || w_done || w_tmo) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        mem.valid   = 1'b0;
        mem.instr   = 1'b0;
        mem.addr    = '0;
        mem.wdata   = '0;
        mem.wstrb   = '0;
        m0.ready    = 1'b0;
        m0.rdata    = '0;
        m1.ready    = 1'b0;
        m1.rdata    = '0;
        timeout_err = w_tmo;
        if (w_busy) begin
            mem.valid = w_req_vld && !w_tmo;
            if (w_sel1) begin
                mem.instr = m1.instr;
                mem.addr  = m1.addr;
                mem.wdata = m1.wdata;
                mem.wstrb = m1.wstrb;
                m1.ready  = w_done || w_tmo;
                m1.rdata  = w_rsp_dat;
            end else begin
                mem.instr = m0.instr;
                mem.addr  = m0.addr;
                mem.wdata = m0.wdata;
                mem.wstrb = m0.wstrb;
                m0.ready  = w_done || w_tmo;
                m0.rdata  = w_rsp_dat;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed corner cases, then random traffic against
// a queue-based reference model with a scoreboard monitor on the master responses.
module tb_mem_bus_arbiter;

    localparam int TO = 15;

    typedef struct {
        int          who;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  grant;
    logic        timeout_err;

    logic [1:0]  tb_valid = 2'b00;
    logic [1:0]  tb_instr = 2'b00;
    logic [31:0] tb_addr  [2] = '{default: 32'h0};
    logic [31:0] tb_wdata [2] = '{default: 32'h0};
    logic [3:0]  tb_wstrb [2] = '{default: 4'h0};
    logic        tb_mready = 1'b0;
    logic [31:0] tb_mrdata = 32'h0;

    logic [1:0]  rdy;
    logic [31:0] rdat [2];

    int          checks = 0;
    int          errors = 0;
    bit          model_on = 1'b0;
    logic [1:0]  exp_grant = 2'b00;
    int          model_last = 1;
    bit          tb_end = 1'b0;
    bit          tb_to = 1'b0;
    int          xfer_n = 0;
    int          sched [5] = '{1, 1, 16, 15, 0};
    rsp_t        exp_q [$];

    always #5 clk = ~clk;

    mem_bus_arbiter_if m0_if ();
    mem_bus_arbiter_if m1_if ();
    mem_bus_arbiter_if mem_if ();

    assign m0_if.valid  = tb_valid[0];
    assign m0_if.instr  = tb_instr[0];
    assign m0_if.addr   = tb_addr[0];
    assign m0_if.wdata  = tb_wdata[0];
    assign m0_if.wstrb  = tb_wstrb[0];
    assign m1_if.valid  = tb_valid[1];
    assign m1_if.instr  = tb_instr[1];
    assign m1_if.addr   = tb_addr[1];
    assign m1_if.wdata  = tb_wdata[1];
    assign m1_if.wstrb  = tb_wstrb[1];
    assign mem_if.ready = tb_mready;
    assign mem_if.rdata = tb_mrdata;
    assign rdy          = {m1_if.ready, m0_if.ready};
    assign rdat[0]      = m0_if.rdata;
    assign rdat[1]      = m1_if.rdata;

    mem_bus_arbiter #(
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .m0          (m0_if),
        .m1          (m1_if),
        .mem         (mem_if),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6)       return $urandom_range(0, 4);
        else if (r == 6) return 14;
        else if (r == 7) return 15;
        else             return $urandom_range(16, 20);
    endfunction

    // Random requester: holds valid until its ready pulse, then re-arms after a gap.
    task automatic run_master(input int x, input int n);
        int gap;
        int waitc;
        tick();
        for (int k = 0; k < n; k++) begin
            gap = (k < 3) ? 0 : $urandom_range(0, 3);
            repeat (gap) tick();
            tb_addr[x]  = $urandom;
            tb_wdata[x] = $urandom;
            tb_wstrb[x] = 4'($urandom_range(0, 15));
            tb_instr[x] = 1'($urandom_range(0, 1));
            tb_valid[x] = 1'b1;
            waitc = 0;
            do begin
                @(negedge clk);
                waitc++;
            end while (!rdy[x] && waitc < 100);
            chk($sformatf("master%0d_wait", x), rdy[x], 1);
            if (!rdy[x]) begin
                tb_valid[x] = 1'b0;
                return;
            end
            tick();
            tb_valid[x] = 1'b0;
        end
    endtask

    // Slave model: picks a latency per transfer and predicts the owner's response.
    task automatic run_slave();
        int          idx;
        int          w;
        int          endi;
        int          own;
        logic [31:0] d;
        bit          inx;
        idx = 0; w = 0; endi = 0; own = 0; d = 32'h0; inx = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            tb_end = 1'b0;
            tb_to  = 1'b0;
            if (!inx && mem_if.valid) begin
                own = (exp_grant == 2'b10) ? 1 : 0;
                chk("req_addr",  mem_if.addr,  tb_addr[own]);
                chk("req_wdata", mem_if.wdata, tb_wdata[own]);
                chk("req_wstrb", mem_if.wstrb, tb_wstrb[own]);
                chk("req_instr", mem_if.instr, tb_instr[own]);
                w = (xfer_n < 5) ? sched[xfer_n] : pick_wait();
                xfer_n++;
                d    = $urandom;
                endi = (w <= TO) ? w : TO;
                exp_q.push_back('{own, (w <= TO) ? d : 32'hFFFF_FFFF, (w > TO)});
                inx = 1'b1;
                idx = 0;
            end
            if (inx) begin
                tb_mready = (idx == w);
                tb_mrdata = (idx == w) ? d : $urandom;
                if (idx == endi) begin
                    tb_end = 1'b1;
                    tb_to  = (w > TO);
                    inx    = 1'b0;
                end else begin
                    idx++;
                end
            end else begin
                tb_mready = 1'($urandom_range(0, 1));
                tb_mrdata = $urandom;
            end
        end
    endtask

    // Scoreboard monitor and round-robin ownership model.
    initial begin
        int   own;
        logic any;
        rsp_t e;
        forever begin
            @(negedge clk);
            if (model_on) begin
                own = (exp_grant == 2'b10) ? 1 : 0;
                any = rdy[0] | rdy[1];
                chk("grant", grant, exp_grant);
                chk("mem_valid", mem_if.valid, (exp_grant != 2'b00) && !(tb_end && tb_to));
                chk("ready_timing", any, tb_end);
                if (any) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_ready", any, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ready_owner", rdy[e.who], 1);
                        chk("ready_other", rdy[1-e.who], 0);
                        chk("rsp_rdata", rdat[e.who], e.data);
                        chk("rsp_timeout_err", timeout_err, e.err);
                    end
                end else begin
                    chk("timeout_err_quiet", timeout_err, 0);
                end
                if (exp_grant == 2'b00) begin
                    chk("idle_rdata0", rdat[0], 0);
                    chk("idle_rdata1", rdat[1], 0);
                    if (tb_valid[0] && tb_valid[1]) exp_grant = (model_last == 1) ? 2'b01 : 2'b10;
                    else if (tb_valid[0])           exp_grant = 2'b01;
                    else if (tb_valid[1])           exp_grant = 2'b10;
                end else begin
                    chk("other_rdata", rdat[1-own], 0);
                    if (tb_end) begin
                        model_last = own;
                        exp_grant  = 2'b00;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "bench did not finish");
    end

    initial begin
        #3;
        chk("rst_grant",       grant,        0);
        chk("rst_mem_valid",   mem_if.valid, 0);
        chk("rst_m0_ready",    m0_if.ready,  0);
        chk("rst_m1_ready",    m1_if.ready,  0);
        chk("rst_timeout_err", timeout_err,  0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // m1 alone reads 0x100, slave answers after three wait cycles
        tick();
        tb_valid[1] = 1'b1; tb_addr[1] = 32'h100; tb_wstrb[1] = 4'h0; tb_instr[1] = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("d1_grant", grant, 2'b10);
            chk("d1_addr", mem_if.addr, 32'h100);
            chk("d1_wait_ready", m1_if.ready, 0);
        end
        tick();
        tb_mready = 1'b1; tb_mrdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("d1_m1_ready", m1_if.ready, 1);
        chk("d1_m1_rdata", m1_if.rdata, 32'hDEAD_BEEF);
        chk("d1_m0_ready", m0_if.ready, 0);
        chk("d1_tmo",      timeout_err, 0);

        // m0 wins the tie, then withdraws; m1 gets the bus after one idle cycle
        tick();
        tb_mready = 1'b0; tb_valid = 2'b11;
        @(negedge clk);
        chk("d2_idle", grant, 2'b00);
        tick();
        @(negedge clk);
        chk("d2_grant0", grant, 2'b01);
        tick();
        tb_valid[0] = 1'b0;
        @(negedge clk);
        chk("d2_drop_grant",     grant,        2'b01);
        chk("d2_drop_mem_valid", mem_if.valid, 0);
        chk("d2_drop_ready",     m0_if.ready,  0);
        tick();
        @(negedge clk);
        chk("d2_idle2",       grant,       2'b00);
        chk("d2_idle2_ready", m0_if.ready, 0);
        tick();
        @(negedge clk);
        chk("d2_grant1", grant, 2'b10);
        tick();
        tb_mready = 1'b1;
        @(negedge clk);
        chk("d2_m1_ready", m1_if.ready, 1);

        // m0 completes (last owner m0), m1 starts, reset lands mid-transfer
        tick();
        tb_mready = 1'b0; tb_valid = 2'b01;
        tick();
        tb_mready = 1'b1;
        @(negedge clk);
        chk("d3_m0_ready", m0_if.ready, 1);
        tick();
        tb_mready = 1'b0; tb_valid = 2'b10;
        tick();
        @(negedge clk);
        chk("d3_grant1",     grant,        2'b10);
        chk("d3_mem_valid1", mem_if.valid, 1);
        #2;
        resetn = 1'b0; tb_valid = 2'b11;
        #1;
        chk("d3_rst_grant",     grant,        0);
        chk("d3_rst_mem_valid", mem_if.valid, 0);
        chk("d3_rst_m1_ready",  m1_if.ready,  0);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        @(negedge clk);
        chk("d3_post_rst_grant", grant, 2'b01);

        // random traffic from a clean reset
        tb_valid = 2'b00; tb_mready = 1'b0;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        tick();
        model_on = 1'b1;
        fork
            run_slave();
        join_none
        fork
            run_master(0, 25);
            run_master(1, 25);
        join
        repeat (4) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
